// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause field positions, exception
// codes, the handler vector, and helpers that pack the SR and Cause words.
package cp0_pkg;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   localparam int SR_IE     = 0;
   localparam int SR_EXL    = 1;
   localparam int SR_IM_LO  = 10;
   localparam int SR_IM_HI  = 15;
   localparam int CAUSE_BD  = 31;
   localparam int CAUSE_IP_LO = 10;
   localparam int CAUSE_EXC_LO = 2;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

   function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl, input logic ie);
      return {16'b0, im, 8'b0, exl, ie};
   endfunction

   function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip, input logic [4:0] exc);
      return {bd, 15'b0, ip, 3'b0, exc, 2'b0};
   endfunction

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// Pipeline <-> CP0 signal bundle. The pipeline (master) drives register access,
// M-stage status and interrupt lines; CP0 (slave) returns IntReq, EPC and Dout.
// IntReq/Dout are combinational on the same cycle; no valid/ready handshake.
interface cp0_int_ctrl_if;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] Din;
   logic        We;
   logic [31:0] PC;
   logic        BD;
   logic [4:0]  ExcCode;
   logic [7:2]  HWInt;
   logic        EXLClr;
   logic        IntReq;
   logic [31:0] EPC;
   logic [31:0] Dout;

   modport master (output A1, A2, Din, We, PC, BD, ExcCode, HWInt, EXLClr,
                   input  IntReq, EPC, Dout);
   modport slave  (input  A1, A2, Din, We, PC, BD, ExcCode, HWInt, EXLClr,
                   output IntReq, EPC, Dout);
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky match flag that drives IP[7].
// Only instantiated when CP0_TIMER_EN is defined.
import cp0_pkg::*;

module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti_pend
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         compare <= '0;
         ti_pend <= 1'b0;
      end else begin
         count <= (we && addr == REG_COUNT) ? din : count + 32'd1;
         // Rewriting Compare acknowledges the timer interrupt.
         if (we && addr == REG_COMPARE) begin
            compare <= din;
            ti_pend <= 1'b0;
         end else if (count == compare && compare != 32'd0) begin
            ti_pend <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PrID and entry/eret control.
// Define CP0_TIMER_EN to add the Count/Compare timer feeding IP[7].
import cp0_pkg::*;

module cp0_int_ctrl #(
   parameter logic [31:0] PRID      = 32'h2021_0707,
   parameter logic [5:0]  SR_IM_RST = 6'h00
) (
   input  logic            clk,
   input  logic            reset,
   cp0_int_ctrl_if.slave   bus
);

   logic [5:0]  im_q;
   logic [5:0]  ip_q;
   logic        exl_q;
   logic        ie_q;
   logic        bd_q;
   logic [4:0]  exc_q;
   logic [31:0] epc_q;
   logic [5:0]  hw_eff;
   logic        int_pend;
   logic        exc_pend;
   logic        take;
   logic        wr_ok;
   logic [31:0] dout;

`ifdef CP0_TIMER_EN
   logic [31:0] count;
   logic [31:0] compare;
   logic        ti_pend;

   cp0_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .we      (wr_ok),
      .addr    (bus.A2),
      .din     (bus.Din),
      .count   (count),
      .compare (compare),
      .ti_pend (ti_pend)
   );

   assign hw_eff = {bus.HWInt[7] | ti_pend, bus.HWInt[6:2]};
`else
   assign hw_eff = bus.HWInt;
`endif

   assign int_pend = (|(hw_eff & im_q)) & ie_q & ~exl_q;
   assign exc_pend = (bus.ExcCode != EXC_INT) & ~exl_q;
   assign take     = ~reset & (int_pend | exc_pend);
   // An exception entry in the same cycle discards any mtc0.
   assign wr_ok    = bus.We & ~take;

   assign bus.IntReq = take;
   assign bus.EPC    = epc_q;
   assign bus.Dout   = dout;

   always_ff @(posedge clk) begin
      if (reset) begin
         im_q  <= SR_IM_RST;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         exc_q <= EXC_INT;
         ip_q  <= '0;
         epc_q <= '0;
      end else begin
         ip_q <= hw_eff;
         if (take) begin
            exl_q <= 1'b1;
            bd_q  <= bus.BD;
            exc_q <= int_pend ? EXC_INT : bus.ExcCode;
            epc_q <= bus.BD ? bus.PC - 32'd4 : bus.PC;
         end else begin
            if (wr_ok && bus.A2 == REG_SR) begin
               im_q <= bus.Din[SR_IM_HI:SR_IM_LO];
               ie_q <= bus.Din[SR_IE];
            end
            if (wr_ok && bus.A2 == REG_EPC)
               epc_q <= bus.Din;
            // eret overrides the EXL bit of a simultaneous SR write.
            if (bus.EXLClr)
               exl_q <= 1'b0;
            else if (wr_ok && bus.A2 == REG_SR)
               exl_q <= bus.Din[SR_EXL];
         end
      end
   end

   always_comb begin
      dout = '0;
      case (bus.A1)
         REG_SR:      dout = sr_word(im_q, exl_q, ie_q);
         REG_CAUSE:   dout = cause_word(bd_q, ip_q, exc_q);
         REG_EPC:     dout = epc_q;
         REG_PRID:    dout = PRID;
`ifdef CP0_TIMER_EN
         REG_COUNT:   dout = count;
         REG_COMPARE: dout = compare;
`endif
         default:     dout = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Self-checking bench for cp0_int_ctrl: directed scenarios plus randomized
// traffic against an architectural model of the CP0 registers.
module tb_cp0_int_ctrl;

  localparam logic [31:0] PRID_V = 32'h2021_0707;
  localparam logic [5:0]  IM_RST = 6'h00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_int_ctrl_if bus();

  cp0_int_ctrl #(.PRID(PRID_V), .SR_IM_RST(IM_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model state
  logic [5:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_count, m_compare;

  function automatic logic [5:0] m_hw();
    return bus.HWInt | (m_ti ? 6'b100000 : 6'b000000);
  endfunction

  function automatic logic m_int();
    return ((m_hw() & m_im) != 6'd0) && m_ie && !m_exl;
  endfunction

  function automatic logic m_req();
    return !reset && (m_int() || (bus.ExcCode != 5'd0 && !m_exl));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return 32'(m_im) * 1024 + 32'(m_exl) * 2 + 32'(m_ie);
      5'd13: return (m_bd ? 32'h8000_0000 : 32'd0) + 32'(m_ip) * 1024 + 32'(m_exc) * 4;
      5'd14: return m_epc;
      5'd15: return PRID_V;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Advance model by one edge using the currently driven inputs, then clock.
  task automatic tick();
    logic req, intp, wok;
    req  = m_req();
    intp = m_int();
    wok  = bus.We && !req;
    if (reset) begin
      m_im = IM_RST; m_exl = 0; m_ie = 0; m_bd = 0; m_exc = 0;
      m_ip = 0; m_epc = 0; m_count = 0; m_compare = 0; m_ti = 0;
    end else begin
      m_ip = m_hw();
      if (req) begin
        m_exl = 1;
        m_bd  = bus.BD;
        m_exc = intp ? 5'd0 : bus.ExcCode;
        m_epc = bus.BD ? bus.PC - 32'd4 : bus.PC;
      end else begin
        if (wok && bus.A2 == 5'd12) begin
          m_im = bus.Din[15:10]; m_exl = bus.Din[1]; m_ie = bus.Din[0];
        end
        if (wok && bus.A2 == 5'd14) m_epc = bus.Din;
        if (bus.EXLClr) m_exl = 0;
      end
`ifdef CP0_TIMER_EN
      if (wok && bus.A2 == 5'd11) m_ti = 0;
      else if (m_count == m_compare && m_compare != 0) m_ti = 1;
      if (wok && bus.A2 == 5'd11) m_compare = bus.Din;
      m_count = (wok && bus.A2 == 5'd9) ? bus.Din : m_count + 32'd1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.A1 = 5'd0; bus.A2 = 5'd0; bus.Din = 32'd0; bus.We = 0;
    bus.PC = 32'h0000_3000; bus.BD = 0; bus.ExcCode = 5'd0;
    bus.HWInt = 6'd0; bus.EXLClr = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.A2 = a; bus.Din = d; bus.We = 1;
    tick();
    bus.We = 0;
  endtask

  task automatic test_reset();
    logic [4:0] regs [4];
    regs = '{5'd12, 5'd13, 5'd14, 5'd15};
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    checks++;
    if (bus.IntReq !== 1'b0) begin errors++; $display("FAIL reset_intreq got %b want 0", bus.IntReq); end
    checks++;
    if (bus.EPC !== 32'd0) begin errors++; $display("FAIL reset_epc got %h want 0", bus.EPC); end
    for (int i = 0; i < 4; i++) begin
      bus.A1 = regs[i]; #1;
      checks++;
      if (bus.Dout !== m_read(regs[i])) begin
        errors++; $display("FAIL reset_reg%0d got %h want %h", regs[i], bus.Dout, m_read(regs[i]));
      end
    end
  endtask

  task automatic test_interrupt();
    mtc0(5'd12, 32'h0000_0401);
    bus.A1 = 5'd12; #1;
    checks++;
    if (bus.Dout !== 32'h0000_0401) begin errors++; $display("FAIL int_sr_write got %h want 00000401", bus.Dout); end
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_1000; #1;
    checks++;
    if (bus.IntReq !== 1'b1) begin errors++; $display("FAIL int_intreq got %b want 1", bus.IntReq); end
    tick();
    bus.A1 = 5'd13; #1;
    checks++;
    if (bus.Dout !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got %h want 00000400", bus.Dout); end
    checks++;
    if (bus.EPC !== 32'h0000_1000) begin errors++; $display("FAIL int_epc got %h want 00001000", bus.EPC); end
    bus.A1 = 5'd12; #1;
    checks++;
    if (bus.Dout !== 32'h0000_0403) begin errors++; $display("FAIL int_exl got %h want 00000403", bus.Dout); end
    bus.HWInt = 6'd0; bus.EXLClr = 1;
    tick();
    bus.EXLClr = 0;
  endtask

  task automatic test_exception();
    mtc0(5'd12, 32'd0);
    bus.ExcCode = 5'd12; bus.PC = 32'h0000_3010; bus.BD = 1; #1;
    checks++;
    if (bus.IntReq !== 1'b1) begin errors++; $display("FAIL exc_intreq got %b want 1", bus.IntReq); end
    tick();
    bus.ExcCode = 5'd0; bus.BD = 0; bus.A1 = 5'd13; #1;
    checks++;
    if (bus.EPC !== 32'h0000_300C) begin errors++; $display("FAIL exc_epc got %h want 0000300c", bus.EPC); end
    checks++;
    if (bus.Dout[31] !== 1'b1 || bus.Dout[6:2] !== 5'd12) begin
      errors++; $display("FAIL exc_cause got %h want bd=1 exc=12", bus.Dout);
    end
    bus.EXLClr = 1;
    tick();
    bus.EXLClr = 0;
  endtask

  task automatic test_priority();
    mtc0(5'd12, 32'h0000_0401);
    bus.HWInt = 6'b000001; bus.ExcCode = 5'd10; bus.PC = 32'h0000_2000;
    bus.We = 1; bus.A2 = 5'd14; bus.Din = 32'hDEAD_BEEF; #1;
    checks++;
    if (bus.IntReq !== 1'b1) begin errors++; $display("FAIL prio_intreq got %b want 1", bus.IntReq); end
    tick();
    bus.We = 0; bus.ExcCode = 5'd0; bus.A1 = 5'd13; #1;
    checks++;
    if (bus.Dout[6:2] !== 5'd0) begin errors++; $display("FAIL prio_exccode got %0d want 0", bus.Dout[6:2]); end
    checks++;
    if (bus.EPC !== 32'h0000_2000) begin errors++; $display("FAIL prio_epc got %h want 00002000", bus.EPC); end
  endtask

  task automatic test_exl_mask();
    #1;
    checks++;
    if (bus.IntReq !== 1'b0) begin errors++; $display("FAIL exl_mask got %b want 0", bus.IntReq); end
    bus.EXLClr = 1;
    tick();
    bus.EXLClr = 0; #1;
    checks++;
    if (bus.IntReq !== 1'b1) begin errors++; $display("FAIL exl_unmask got %b want 1", bus.IntReq); end
    bus.HWInt = 6'd0; #1;
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_eret_write();
    mtc0(5'd12, 32'h0000_0002);
    bus.A2 = 5'd12; bus.Din = 32'h0000_0403; bus.We = 1; bus.EXLClr = 1;
    tick();
    bus.We = 0; bus.EXLClr = 0; bus.A1 = 5'd12; #1;
    checks++;
    if (bus.Dout !== 32'h0000_0401) begin errors++; $display("FAIL eret_write got %h want 00000401", bus.Dout); end
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_read();
    bus.A1 = 5'd15; #1;
    checks++;
    if (bus.Dout !== 32'h2021_0707) begin errors++; $display("FAIL read_prid got %h want 20210707", bus.Dout); end
    bus.A1 = 5'd20; #1;
    checks++;
    if (bus.Dout !== 32'd0) begin errors++; $display("FAIL read_unimpl got %h want 0", bus.Dout); end
    bus.A1 = 5'd11; #1;
    checks++;
    if (bus.Dout !== m_read(5'd11)) begin errors++; $display("FAIL read_compare got %h want %h", bus.Dout, m_read(5'd11)); end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    logic seen;
    idle();
    reset = 1; tick(); reset = 0;
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_8001);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      checks++;
      if (bus.IntReq !== m_req()) begin errors++; $display("FAIL timer_wait got %b want %b", bus.IntReq, m_req()); end
      if (bus.IntReq === 1'b1) seen = 1;
      tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL timer_fire got 0 want 1 within 20 cycles"); end
    mtc0(5'd11, 32'd100);
    bus.EXLClr = 1; tick(); bus.EXLClr = 0; #1;
    checks++;
    if (bus.IntReq !== 1'b0) begin errors++; $display("FAIL timer_ack got %b want 0", bus.IntReq); end
    bus.A1 = 5'd9; #1;
    checks++;
    if (bus.Dout !== m_count) begin errors++; $display("FAIL timer_count got %h want %h", bus.Dout, m_count); end
  endtask
`endif

  task automatic test_random();
    logic [4:0] wr_regs [7];
    logic [4:0] excs [4];
    wr_regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    excs    = '{5'd4, 5'd5, 5'd10, 5'd12};
    idle();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      bus.A1      = 5'($urandom_range(0, 20));
      bus.A2      = wr_regs[$urandom_range(0, 6)];
      bus.Din     = $urandom;
      bus.We      = ($urandom_range(0, 2) == 0);
      bus.PC      = {$urandom, 2'b00} & 32'h0000_FFFC;
      bus.BD      = 1'($urandom_range(0, 1));
      bus.ExcCode = ($urandom_range(0, 7) == 0) ? excs[$urandom_range(0, 3)] : 5'd0;
      bus.HWInt   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      bus.EXLClr  = ($urandom_range(0, 5) == 0);
      #1;
      checks++;
      if (bus.IntReq !== m_req()) begin errors++; $display("FAIL rand_intreq i=%0d got %b want %b", i, bus.IntReq, m_req()); end
      checks++;
      if (bus.Dout !== m_read(bus.A1)) begin
        errors++; $display("FAIL rand_dout i=%0d a1=%0d got %h want %h", i, bus.A1, bus.Dout, m_read(bus.A1));
      end
      checks++;
      if (bus.EPC !== m_epc) begin errors++; $display("FAIL rand_epc i=%0d got %h want %h", i, bus.EPC, m_epc); end
      tick();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    m_ti = 0; m_count = 0; m_compare = 0;
    test_reset();
    test_interrupt();
    test_exception();
    test_priority();
    test_exl_mask();
    test_eret_write();
    test_read();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_int_ctrl.md
Name: cp0_int_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller; consumes timer IRQ lines (TC0/TC1) and external device interrupts on HWInt.
- Holds SR/Cause/EPC/PrID; tells the pipeline when to flush and jump to the handler, and returns EPC for eret.
- Sits beside the M stage; mfc0/mtc0 access it via register number.

Parameters:
- PRID, 32'h2021_0707, read-only value of PrID (reg 15).
- SR_IM_RST, 6'h00, reset value of SR.IM[15:10].

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- A1  in  5  CP0 register number for read (mfc0)
- A2  in  5  CP0 register number for write (mtc0)
- Din  in  32  mtc0 write data
- We  in  1  mtc0 write enable
- PC  in  32  PC of the M-stage instruction (word aligned)
- BD  in  1  M-stage instruction sits in a delay slot
- ExcCode  in  5  exception code of M-stage instruction; 0 = none
- HWInt  in  6  hardware interrupts [7:2]; bit 2 = TC0.IRQ, bit 3 = TC1.IRQ
- EXLClr  in  1  eret in M stage
- IntReq  out  1  take exception/interrupt this cycle (flush + vector 0x4180)
- EPC  out  32  current EPC value
- Dout  out  32  read data for A1

Behaviour:
- Registers: SR(12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; Cause(13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}; EPC(14) 32b; PrID(15) = PRID.
- Reset: IM = SR_IM_RST, EXL = 0, IE = 0, Cause = 0, EPC = 0; IntReq = 0, Dout follows A1.
- Dout combinational: mux on A1; unimplemented numbers read 0.
- IP[7:2] <= HWInt every cycle, including exception cycles. Not writable by mtc0.
- int_pend = |(HWInt & IM) & IE & ~EXL. exc_pend = (ExcCode != 0) & ~EXL.
- IntReq = int_pend | exc_pend. Combinational, same-cycle with inputs.
- Interrupt has priority over exception when both are pending.
- Entry, at the clock edge with IntReq = 1:
  - EXL <= 1; BD <= BD.
  - ExcCode field <= 0 for an interrupt, else the ExcCode input.
  - EPC <= BD ? PC - 4 : PC.
- mtc0:
  - Only SR (IM, EXL, IE bits) and EPC are writable; writes to others are ignored.
  - If IntReq and We are both high, IntReq wins and the write is discarded.
- EXLClr:
  - Clears EXL at the edge; no effect if EXL = 0.
  - If We targets SR in the same cycle, the mtc0 value is applied first, then EXL is forced to 0.
- EPC written to a non-word-aligned value is stored as-is; the pipeline handles AdEL.
- Reset mid-handler clears EXL immediately and drops all pending state.
- Write latency: mtc0 is visible on Dout the next cycle; no internal bypass.

Optional Feature:
- Macro CP0_TIMER_EN.
- Enabled:
  - Count(9) increments every non-reset cycle and wraps at 2^32.
  - Compare(11) is writable.
  - When Count == Compare and Compare != 0, sticky ti_pend <= 1.
  - IP[7] = HWInt[7] | ti_pend; any mtc0 to Compare clears ti_pend.
  - Count is writable; a write overrides the increment that cycle.
- Disabled:
  - Regs 9/11 read 0 and writes are ignored.
  - IP[7] = HWInt[7] only; no extra flops.

Decomposition:
- cp0_pkg holds:
  - register numbers: SR=12, CAUSE=13, EPC=14, PRID=15, COUNT=9, COMPARE=11;
  - SR/Cause bit positions;
  - ExcCodes: Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - vector 32'h0000_4180.
- One sub-module, cp0_timer, holds Count/Compare/ti_pend and is instantiated only under CP0_TIMER_EN.

Test Plan:
- mtc0 SR = 32'h0000_0401, then HWInt = 6'b000001 -> IntReq = 1 same cycle; next cycle: EXL = 1, Cause = 32'h0000_0400, EPC = PC.
- ExcCode = 12, PC = 0x3010, BD = 1, EXL = 0 -> IntReq = 1; next cycle: EPC = 0x300C, Cause[31] = 1, Cause[6:2] = 12.
- Same cycle: interrupt pending plus ExcCode = 10 plus We to EPC -> ExcCode field 0, EPC = PC, mtc0 value discarded.
- EXL = 1, HWInt asserted -> IntReq = 0; pulse EXLClr -> IntReq = 1 on the following cycle.
- mfc0 A1 = 15 -> Dout = 32'h2021_0707; A1 = 20 -> 0.
- CP0_TIMER_EN: Compare = 5, SR = 32'h0000_8001 -> IntReq once Count reaches 5; write Compare = 100 -> IntReq drops next cycle.
